// File: rtl/alu_pkg.sv
// Shared types for the execution-stage ALU: operation codes, FSM states, shift classifier.
// Optional build macro ALU_BARREL_SHIFT_EN is consumed by alu_comb_core and alu_seq_exec.
package alu_pkg;

   typedef enum logic [3:0] {
      ALU_ADD  = 4'b0000,
      ALU_SUB  = 4'b0001,
      ALU_AND  = 4'b0010,
      ALU_OR   = 4'b0011,
      ALU_XOR  = 4'b0100,
      ALU_SLL  = 4'b0101,
      ALU_SRL  = 4'b0110,
      ALU_SRA  = 4'b0111,
      ALU_SLTU = 4'b1000,
      ALU_SLT  = 4'b1001
   } alu_op_t;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

   function automatic logic is_shift(alu_op_t op);
      return (op == ALU_SLL) || (op == ALU_SRL) || (op == ALU_SRA);
   endfunction

endpackage

// File: rtl/alu_comb_core.sv
// Single-cycle ALU operations and illegal-code detection.
// With ALU_BARREL_SHIFT_EN defined, shifts are computed here too; otherwise shifts pass A through.
module alu_comb_core
   import alu_pkg::*;
#(
   parameter int WIDTH   = 32,
   parameter int SHAMT_W = $clog2(WIDTH)
) (
   input  alu_op_t          op_i,
   input  logic [WIDTH-1:0] a_i,
   input  logic [WIDTH-1:0] b_i,
   output logic [WIDTH-1:0] result_o,
   output logic             illegal_o
);

`ifdef ALU_BARREL_SHIFT_EN
   logic [SHAMT_W-1:0] shamt;
   assign shamt = b_i[SHAMT_W-1:0];
`endif

   always_comb begin
      result_o  = '0;
      illegal_o = 1'b0;
      case (op_i)
         ALU_ADD:  result_o = a_i + b_i;
         ALU_SUB:  result_o = a_i - b_i;
         ALU_AND:  result_o = a_i & b_i;
         ALU_OR:   result_o = a_i | b_i;
         ALU_XOR:  result_o = a_i ^ b_i;
         ALU_SLTU: result_o = {{(WIDTH-1){1'b0}}, (a_i < b_i)};
         ALU_SLT:  result_o = {{(WIDTH-1){1'b0}}, ($signed(a_i) < $signed(b_i))};
`ifdef ALU_BARREL_SHIFT_EN
         ALU_SLL:  result_o = a_i << shamt;
         ALU_SRL:  result_o = a_i >> shamt;
         ALU_SRA:  result_o = WIDTH'($signed(a_i) >>> shamt);
`else
         // Iterative build: A seeds the shift register (and is the answer for shamt=0).
         ALU_SLL, ALU_SRL, ALU_SRA: result_o = a_i;
`endif
         default:  illegal_o = 1'b1;
      endcase
   end

endmodule

// File: rtl/alu_seq_exec.sv
// Execution-stage ALU with valid/ready on both sides; shifts iterate one bit per cycle
// unless ALU_BARREL_SHIFT_EN is defined, in which case every op takes the 1-cycle path.
module alu_seq_exec
   import alu_pkg::*;
#(
   parameter int WIDTH   = 32,
   parameter int SHAMT_W = $clog2(WIDTH)
) (
   input  logic             CLK,
   input  logic             RST_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  alu_op_t          ALU_control,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic             zero,
   output logic             illegal,
   output state_t           dbg_state_o
);

   // Handshake: an op is accepted on a rising edge where in_valid && in_ready; a result
   // is consumed on an edge where out_valid && out_ready. in_ready is high only in IDLE,
   // out_valid only in DONE, and result/zero/illegal hold steady until consumed.

   state_t           state_q, state_d;
   logic [WIDTH-1:0] result_q, result_d;
   logic             zero_q, zero_d;
   logic             illegal_q, illegal_d;
   logic [WIDTH-1:0] core_result;
   logic             core_illegal;

`ifndef ALU_BARREL_SHIFT_EN
   alu_op_t            op_q, op_d;
   logic [SHAMT_W-1:0] cnt_q, cnt_d;
   logic [SHAMT_W-1:0] shamt;
   assign shamt = B[SHAMT_W-1:0];
`endif

   alu_comb_core #(.WIDTH(WIDTH), .SHAMT_W(SHAMT_W)) u_core (
      .op_i      (ALU_control),
      .a_i       (A),
      .b_i       (B),
      .result_o  (core_result),
      .illegal_o (core_illegal)
   );

   always_comb begin
      state_d   = state_q;
      result_d  = result_q;
      zero_d    = zero_q;
      illegal_d = illegal_q;
      in_ready  = 1'b0;
      out_valid = 1'b0;
`ifndef ALU_BARREL_SHIFT_EN
      op_d      = op_q;
      cnt_d     = cnt_q;
`endif
      case (state_q)
         IDLE: begin
            in_ready = 1'b1;
            if (in_valid) begin
               result_d  = core_result;
               zero_d    = (core_result == '0);
               illegal_d = core_illegal;
               state_d   = DONE;
`ifndef ALU_BARREL_SHIFT_EN
               if (is_shift(ALU_control) && (shamt != '0)) begin
                  op_d    = ALU_control;
                  cnt_d   = shamt;
                  state_d = SHIFT;
               end
`endif
            end
         end
`ifndef ALU_BARREL_SHIFT_EN
         SHIFT: begin
            case (op_q)
               ALU_SLL: result_d = {result_q[WIDTH-2:0], 1'b0};
               ALU_SRL: result_d = {1'b0, result_q[WIDTH-1:1]};
               default: result_d = {result_q[WIDTH-1], result_q[WIDTH-1:1]};
            endcase
            zero_d = (result_d == '0);
            cnt_d  = cnt_q - SHAMT_W'(1);
            if (cnt_q == SHAMT_W'(1)) state_d = DONE;
         end
`endif
         DONE: begin
            out_valid = 1'b1;
            if (out_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge CLK or negedge RST_n) begin
      if (!RST_n) begin
         state_q   <= IDLE;
         result_q  <= '0;
         zero_q    <= 1'b1;
         illegal_q <= 1'b0;
`ifndef ALU_BARREL_SHIFT_EN
         op_q      <= ALU_ADD;
         cnt_q     <= '0;
`endif
      end else begin
         state_q   <= state_d;
         result_q  <= result_d;
         zero_q    <= zero_d;
         illegal_q <= illegal_d;
`ifndef ALU_BARREL_SHIFT_EN
         op_q      <= op_d;
         cnt_q     <= cnt_d;
`endif
      end
   end

   assign result      = result_q;
   assign zero        = zero_q;
   assign illegal     = illegal_q;
   assign dbg_state_o = state_q;

endmodule
